// File: rtl/sqnorm_bound_check_pkg.sv
// Shared constants for the squared-norm bound check: widths, per-degree
// L2 bounds and the controller state encoding.
package sqnorm_bound_check_pkg;

  localparam int COEF_W   = 16;
  localparam int NORM_W   = 32;
  localparam int LOGN_MAX = 10;

  // Acceptance bound on the squared norm, indexed by logn.
  localparam logic [NORM_W-1:0] L2BOUND [0:LOGN_MAX] = '{
    32'd0,
    32'd101498,
    32'd208714,
    32'd428865,
    32'd892039,
    32'd1852696,
    32'd3842630,
    32'd7959734,
    32'd16468416,
    32'd34034726,
    32'd70265242
  };

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;

endpackage

// File: rtl/sat_sq_acc.sv
// Square-and-saturating-accumulate datapath: acc += coef*coef, clamping at
// all-ones with a sticky overflow flag.
module sat_sq_acc
  import sqnorm_bound_check_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NORM_W-1:0] load_value,
  input  logic              add_en,
  input  logic [COEF_W-1:0] coef,
  output logic [NORM_W-1:0] acc,
  output logic              overflow
);

  logic signed [NORM_W-1:0] coef_x;
  logic signed [NORM_W-1:0] sq;
  logic        [NORM_W:0]   sum;

  // NOTE: every signal written here gets a value on every pass, so no latch is inferred.
  always_comb begin
    coef_x = NORM_W'(signed'(coef));
    // Largest square is (-32768)^2 = 2^30, which is non-negative in 32 bits.
    sq     = coef_x * coef_x;
    sum    = {1'b0, acc} + {1'b0, sq};
  end

  // NOTE: registered state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      acc      <= load_value;
      overflow <= 1'b0;
    end else if (add_en) begin
      // Once at all-ones any further non-zero add carries out, keeping it pinned.
      if (sum[NORM_W]) begin
        acc      <= '1;
        overflow <= 1'b1;
      end else begin
        acc <= sum[NORM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sqnorm_bound_check.sv
// Streams N = 2^logn signed coefficients, accumulates their squares on top
// of an upstream partial norm, and compares the total with L2BOUND[logn].
module sqnorm_bound_check
  import sqnorm_bound_check_pkg::*;
#(
  parameter int logn = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NORM_W-1:0] norm_in,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef,
  output logic              coef_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NORM_W-1:0] sqn
);

  localparam int                CNT_W = logn + 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'((1 << logn) - 1);
  localparam logic [NORM_W-1:0] BOUND = L2BOUND[logn];

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              load;
  logic [NORM_W-1:0] acc;
  logic              overflow;

  assign coef_ready = (state == ST_ACC);
  assign busy       = (state == ST_ACC) || (state == ST_CMP);
  assign accept     = coef_valid && coef_ready;
  assign load       = (state == ST_IDLE) && start;

  sat_sq_acc u_sat_sq_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_value (norm_in),
    .add_en     (accept),
    .coef       (coef),
    .acc        (acc),
    .overflow   (overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
      sqn   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ACC;
            cnt   <= '0;
            pass  <= 1'b0;
            sqn   <= '0;
          end
        end
        ST_ACC: begin
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) state <= ST_CMP;
          end
        end
        ST_CMP: begin
          // acc already holds the Nth square here, so the verdict is one edge later.
          pass  <= (acc <= BOUND) && !overflow;
          sqn   <= acc;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
